// File: rtl/gray_binary_rx.sv
// Gray-coded count receiver: synchronises, decodes to binary, reports single-step direction and flags multi-bit jumps.
// Optional saturating error counter output err_cnt is enabled by defining GRAY_BINARY_RX_ERR_CNT_EN.
module gray_binary_rx #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] g_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] b_out,
    output logic             b_valid,
    output logic             b_dir,
    output logic             step_err,
    output logic             err_sticky
`ifdef GRAY_BINARY_RX_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    localparam int WARM_W = $clog2(SYNC_STAGES + 2);
    localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(SYNC_STAGES + 1);
    localparam logic [WIDTH-1:0]  ONE       = WIDTH'(1);

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]  gs;
    logic [WIDTH-1:0]  prev_q;
    logic [WIDTH-1:0]  b_out_q, b_out_d;
    logic              b_valid_q, b_valid_d;
    logic              b_dir_q, b_dir_d;
    logic              step_err_q, step_err_d;
    logic              sticky_q, sticky_d;
    logic [WARM_W-1:0] warm_q, warm_d;

    logic [WIDTH-1:0]  diff;
    logic              one_bit, multi_bit, warm, step_up;

    assign gs = sync_q[SYNC_STAGES-1];

    // Plain flop chain: any logic between stages would defeat the metastability filtering.
    // NOTE: the synchroniser array is a handful of flops, not a RAM, so resetting every entry is cheap and keeps the first decode deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage sample the previous stage's old value, forming a true shift chain.
            sync_q[0] <= g_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
        diff       = gs ^ prev_q;
        one_bit    = (diff != '0) && ((diff & (diff - ONE)) == '0);
        multi_bit  = (diff & (diff - ONE)) != '0;
        warm       = warm_q != '0;
        step_up    = gray2bin(gs) == (gray2bin(prev_q) + ONE);

        b_out_d    = gray2bin(gs);
        b_valid_d  = one_bit && !warm;
        step_err_d = multi_bit && !warm;
        b_dir_d    = b_dir_q;
        if (b_valid_d) begin
            b_dir_d = step_up;
        end
        // A new error outranks a simultaneous clear.
        sticky_d   = step_err_d || (sticky_q && !err_clr);
        warm_d     = warm ? warm_q - 1'b1 : warm_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            b_out_q    <= '0;
            b_valid_q  <= 1'b0;
            b_dir_q    <= 1'b0;
            step_err_q <= 1'b0;
            sticky_q   <= 1'b0;
            warm_q     <= WARM_LOAD;
        end else begin
            prev_q     <= gs;
            b_out_q    <= b_out_d;
            b_valid_q  <= b_valid_d;
            b_dir_q    <= b_dir_d;
            step_err_q <= step_err_d;
            sticky_q   <= sticky_d;
            warm_q     <= warm_d;
        end
    end

    assign b_out      = b_out_q;
    assign b_valid    = b_valid_q;
    assign b_dir      = b_dir_q;
    assign step_err   = step_err_q;
    assign err_sticky = sticky_q;

`ifdef GRAY_BINARY_RX_ERR_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (err_clr) begin
            cnt_d = {7'b0, step_err_d};
        end else if (step_err_d && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_gray_binary_rx.sv
// Scoreboard bench for gray_binary_rx: stimulus pushes expected pulses, a negedge monitor pops and compares.
module tb_gray_binary_rx;

    typedef struct {
        logic       is_err;
        logic [3:0] b;
        logic       dir;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] g_in;
    logic       err_clr;
    logic [3:0] b_out;
    logic       b_valid, b_dir, step_err, err_sticky;
`ifdef GRAY_BINARY_RX_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t exp_q [$];
    logic [3:0] gray_tab [16];

    gray_binary_rx #(.WIDTH(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .g_in       (g_in),
        .err_clr    (err_clr),
        .b_out      (b_out),
        .b_valid    (b_valid),
        .b_dir      (b_dir),
        .step_err   (step_err),
        .err_sticky (err_sticky)
`ifdef GRAY_BINARY_RX_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected response appears SYNC_STAGES+1 = 3 edges after the drive.
    task automatic drive(input logic [3:0] g, input logic is_err, input logic [3:0] b, input logic dir);
        exp_t e;
        e.is_err = is_err;
        e.b      = b;
        e.dir    = dir;
        e.cyc    = cyc + 3;
        exp_q.push_back(e);
        g_in = g;
        tick(4);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (b_valid === 1'b1 || step_err === 1'b1)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: b_valid=%b step_err=%b b_out=%0d, expected none (cycle %0d)",
                         b_valid, step_err, b_out, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind_err", {31'b0, step_err}, {31'b0, e.is_err});
                check("pulse_kind_valid", {31'b0, b_valid}, {31'b0, ~e.is_err});
                check("pulse_b_out", {28'b0, b_out}, {28'b0, e.b});
                check("pulse_b_dir", {31'b0, b_dir}, {31'b0, e.dir});
                check("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        gray_tab[0]  = 4'b0000; gray_tab[1]  = 4'b0001; gray_tab[2]  = 4'b0011; gray_tab[3]  = 4'b0010;
        gray_tab[4]  = 4'b0110; gray_tab[5]  = 4'b0111; gray_tab[6]  = 4'b0101; gray_tab[7]  = 4'b0100;
        gray_tab[8]  = 4'b1100; gray_tab[9]  = 4'b1101; gray_tab[10] = 4'b1111; gray_tab[11] = 4'b1110;
        gray_tab[12] = 4'b1010; gray_tab[13] = 4'b1011; gray_tab[14] = 4'b1001; gray_tab[15] = 4'b1000;

        rst_n   = 1'b0;
        g_in    = 4'b0110;
        err_clr = 1'b0;
        tick(2);
        check("rst_b_out", {28'b0, b_out}, 32'd0);
        check("rst_b_valid", {31'b0, b_valid}, 32'd0);
        check("rst_step_err", {31'b0, step_err}, 32'd0);
        check("rst_err_sticky", {31'b0, err_sticky}, 32'd0);

        // Warm-up must swallow the 0000 -> 0110 jump; the monitor flags any pulse.
        rst_n = 1'b1;
        tick(3);
        check("warmup_b_out", {28'b0, b_out}, 32'd4);
        check("warmup_err_sticky", {31'b0, err_sticky}, 32'd0);
        tick(2);

        rst_n = 1'b0;
        g_in  = 4'b0000;
        #1;
        check("rst2_b_out_async", {28'b0, b_out}, 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(5);
        check("rst2_b_out", {28'b0, b_out}, 32'd0);

        for (int i = 1; i < 16; i++) begin
            drive(gray_tab[i], 1'b0, 4'(i), 1'b1);
        end
        drive(4'b0000, 1'b0, 4'd0, 1'b1);
        drive(4'b1000, 1'b0, 4'd15, 1'b0);
        drive(4'b1001, 1'b0, 4'd14, 1'b0);
        drive(4'b0001, 1'b0, 4'd1, 1'b0);
        check("no_err_before_jump", {31'b0, err_sticky}, 32'd0);

        drive(4'b0110, 1'b1, 4'd4, 1'b0);
        check("jump_err_sticky", {31'b0, err_sticky}, 32'd1);
        check("jump_b_out", {28'b0, b_out}, 32'd4);
`ifdef GRAY_BINARY_RX_ERR_CNT_EN
        check("jump_err_cnt", {24'b0, err_cnt}, 32'd1);
`endif
        drive(4'b0111, 1'b0, 4'd5, 1'b1);
        check("after_jump_sticky", {31'b0, err_sticky}, 32'd1);

        begin
            exp_t e;
            e.is_err = 1'b1;
            e.b      = 4'd0;
            e.dir    = 1'b1;
            e.cyc    = cyc + 3;
            exp_q.push_back(e);
            g_in = 4'b0000;
            tick(2);
            err_clr = 1'b1;
            tick(1);
            err_clr = 1'b0;
            check("clr_vs_err_sticky", {31'b0, err_sticky}, 32'd1);
`ifdef GRAY_BINARY_RX_ERR_CNT_EN
            check("clr_vs_err_cnt", {24'b0, err_cnt}, 32'd1);
`endif
            tick(1);
        end

        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("clr_alone_sticky", {31'b0, err_sticky}, 32'd0);
`ifdef GRAY_BINARY_RX_ERR_CNT_EN
        check("clr_alone_err_cnt", {24'b0, err_cnt}, 32'd0);
`endif

        for (int i = 1; i < 10; i++) begin
            drive(gray_tab[i], 1'b0, 4'(i), 1'b1);
        end
        check("pre_midrst_b_out", {28'b0, b_out}, 32'd9);

        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_b_out", {28'b0, b_out}, 32'd0);
        check("midrst_b_dir", {31'b0, b_dir}, 32'd0);
        check("midrst_b_valid", {31'b0, b_valid}, 32'd0);
        check("midrst_step_err", {31'b0, step_err}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("reconverge_b_out", {28'b0, b_out}, 32'd9);
        check("reconverge_sticky", {31'b0, err_sticky}, 32'd0);
        tick(3);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
